// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, fault cause codes and
// bus/instruction helpers used by the fetch unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

    // Fault cause codes reported on the sticky fault output; code 3 is reserved.
    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

    // Bus data arrives little-endian; the decoder expects byte-reversed words.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one Avalon-MM read per PC value, holds the
// byte-swapped word for decode, and stops on halt address, misalignment or timeout.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR  = DEFAULT_HALT_ADDR,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [31:0] pc_addr,
    output logic        fetch,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    fetch_state_t     state, state_d;
    logic [1:0]       fault_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             abort;
    logic             load_addr;
    logic             load_instr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            fault <= FAULT_NONE;
        end else begin
            state <= state_d;
            fault <= fault_d;
        end
    end

    // abort remembers that active dropped during the bus transaction, so the
    // word is discarded even if active returns before the read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr       <= '0;
            avm_address <= '0;
            wait_cnt    <= '0;
            abort       <= 1'b0;
        end else begin
            if (load_addr) begin
                avm_address <= pc_addr;
                wait_cnt    <= '0;
                abort       <= 1'b0;
            end else if (state == ST_REQ) begin
                if (avm_waitrequest) wait_cnt <= wait_cnt + 1'b1;
                if (!active)         abort    <= 1'b1;
            end
            if (load_instr) instr <= byte_swap32(avm_readdata);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        fault_d     = fault;
        load_addr   = 1'b0;
        load_instr  = 1'b0;
        avm_read    = 1'b0;
        instr_valid = 1'b0;
        fetch       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    if (pc_addr == HALT_ADDR) begin
                        state_d = ST_HALT;
                    end else if (pc_addr[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                        fault_d = FAULT_MISALIGN;
                    end else begin
                        state_d   = ST_REQ;
                        load_addr = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (abort || !active) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_HOLD;
                        load_instr = 1'b1;
                    end
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    // This waitrequest cycle is the WAIT_LIMIT-th one.
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                fetch       = active && !stall;
                if (!active || !stall) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign halted         = (state == ST_HALT);
    assign avm_byteenable = {4{avm_read}};

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter HALT_ADDR, default 32'h0000_0000: fetch address that stops the fetch unit.
REQ-002 Parameter WAIT_LIMIT, default 16: consecutive waitrequest cycles before timeout is flagged.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 active  input  1  CPU run enable; a new fetch starts only while high.
REQ-006 pc_addr  input  32  current PC value; sampled in IDLE.
REQ-007 fetch  output  1  one-cycle pulse that advances the PC on the same posedge.
REQ-008 stall  input  1  downstream decode not ready; holds the current instruction.
REQ-009 instr  output  32  fetched instruction, byte-reversed from bus order.
REQ-010 instr_valid  output  1  instr is valid this cycle.
REQ-011 avm_address  output  32  memory read address.
REQ-012 avm_read  output  1  read request.
REQ-013 avm_byteenable  output  4  always 4'b1111 during a read; 4'b0000 otherwise.
REQ-014 avm_waitrequest  input  1  memory not ready; request must be held.
REQ-015 avm_readdata  input  32  read data; valid in the cycle avm_read=1 and waitrequest=0.
REQ-016 halted  output  1  sticky; fetch stopped (HALT_ADDR, misaligned PC, or timeout).
REQ-017 fault  output  2  sticky cause: 0 none, 1 misaligned, 2 timeout, 3 reserved.

Function
REQ-018 FSM states: IDLE, REQ, HOLD, HALT.
REQ-019 IDLE, with active=1: if pc_addr==HALT_ADDR, go to HALT with fault=0; else if pc_addr[1:0]!=0, go to HALT with fault=1; else latch pc_addr into avm_address and go to REQ.
REQ-020 IDLE, with active=0: remain in IDLE with outputs idle.
REQ-021 REQ: avm_read=1; avm_address is stable; remain in REQ while avm_waitrequest=1.
REQ-022 REQ, waitrequest=0: instr <= {readdata[7:0],readdata[15:8],readdata[23:16],readdata[31:24]}; go to HOLD.
REQ-023 Wait counter: clears on REQ entry and increments each waitrequest=1 cycle.
REQ-024 Timeout: when the wait counter reaches WAIT_LIMIT, the unit drops avm_read, goes to HALT, and sets fault=2.
REQ-025 HOLD: instr_valid=1; fetch = (state==HOLD && !stall), combinational.
REQ-026 HOLD, stall=0: go to IDLE next cycle.
REQ-027 HOLD, stall=1: remain in HOLD; instr is held unchanged.
REQ-028 Zero-wait throughput: one instruction per 3 cycles (IDLE, REQ, HOLD).
REQ-029 active falling while in REQ: the transaction completes (avm_read is not dropped under waitrequest), then the FSM goes to IDLE without raising instr_valid.
REQ-030 active falling while in HOLD: the FSM returns to IDLE; no fetch pulse is issued.
REQ-031 HALT: terminal; avm_read=0, instr_valid=0, fetch=0, halted=1; only reset exits.
REQ-032 instr_valid and avm_read are never high in the same cycle.

Reset
REQ-033 Asserting reset (low) at any time, including mid-REQ, forces the following immediately: state=IDLE, instr=0, avm_address=0, avm_read=0, instr_valid=0, fetch=0, halted=0, fault=0, wait counter=0.
REQ-034 The first fetch begins in the first clk edge after reset deasserts, provided active=1.

Structure
REQ-035 Shared package cpu_pkg holds: the fetch_state_t enum, the fault code constants, the default HALT_ADDR, and a byte_swap32 function.
REQ-036 No sub-module is required; the block is a single FSM with a datapath register.

Verification
REQ-037 Reset, then active=1, pc_addr=32'h4, readdata=32'h78563412, waitrequest=0 -> avm_address=4 in cycle 1; instr=32'h12345678 with instr_valid=1 in cycle 2; fetch pulse in cycle 2.
REQ-038 waitrequest high for 3 cycles -> avm_read and avm_address are stable for 4 cycles; instr_valid is raised the cycle after waitrequest falls.
REQ-039 stall=1 for 5 cycles in HOLD -> instr_valid=1 and instr is constant; no fetch pulse until stall=0.
REQ-040 pc_addr=32'h0 -> halted=1 and fault=0 next cycle; avm_read is never asserted; pc_addr=32'h6 -> halted=1, fault=1.
REQ-041 waitrequest held high for 16 cycles -> avm_read=0, halted=1, fault=2.
REQ-042 reset pulsed low mid-REQ -> all outputs are 0 within the same cycle; a fresh fetch of pc_addr starts after release.
